// File: rtl/sdram_frame_arbiter.sv
// sdram_frame_arbiter
//   Shares one SDRAM burst engine between the camera write FIFO, the VGA read
//   FIFO and periodic auto-refresh. It also generates burst addresses for a
//   ping-pong pair of frame buffers, so the display always reads the last
//   complete camera frame.
//
// Ports
//   sys_clk, rst       clock (rising edge) and asynchronous active-high reset
//   init_done          SDRAM power-up done; only sampled while waiting for it
//   wr_fifo_level      words waiting in the camera write FIFO
//   rd_fifo_level      words held in the VGA read FIFO
//   wr_frame_start     one-cycle camera frame start pulse
//   rd_frame_start     one-cycle display frame start pulse
//   cmd_valid/ready    command handshake towards the SDRAM engine
//   cmd_op             01 write burst, 10 read burst, 11 auto-refresh
//   cmd_addr           burst start word address (0 for refresh)
//   cmd_done           engine pulse when the accepted command has finished
//   rd_buf_sel         buffer currently being displayed
//   ref_overrun        sticky: a refresh came due while one was still pending
module sdram_frame_arbiter #(
    parameter int unsigned       ADDR_W       = 22,
    parameter int unsigned       BURST_LEN    = 8,
    parameter int unsigned       FIFO_AW      = 9,
    parameter int unsigned       FRAME_WORDS  = 307200,
    parameter logic [ADDR_W-1:0] BUF1_BASE    = 22'h200000,
    parameter int unsigned       REF_INTERVAL = 156
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              init_done,
    input  logic [FIFO_AW:0]  wr_fifo_level,
    input  logic [FIFO_AW:0]  rd_fifo_level,
    input  logic              wr_frame_start,
    input  logic              rd_frame_start,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_done,
    output logic              rd_buf_sel,
    output logic              ref_overrun
);

    localparam int unsigned       REF_W      = $clog2(REF_INTERVAL);
    localparam logic [REF_W-1:0]  REF_RELOAD = REF_W'(REF_INTERVAL - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST   = ADDR_W'(FRAME_WORDS - BURST_LEN);
    localparam logic [ADDR_W-1:0] PTR_STEP   = ADDR_W'(BURST_LEN);
    localparam logic [FIFO_AW:0]  WR_MIN     = (FIFO_AW + 1)'(BURST_LEN);
    // Free space >= BURST_LEN, rewritten so it cannot underflow.
    localparam logic [FIFO_AW:0]  RD_MAX     = (FIFO_AW + 1)'((2 ** FIFO_AW) - BURST_LEN);

    localparam logic [1:0] OpWrite   = 2'b01;
    localparam logic [1:0] OpRead    = 2'b10;
    localparam logic [1:0] OpRefresh = 2'b11;

    typedef enum logic [1:0] {StWaitInit, StIdle, StIssue, StBusy} state_e;

    state_e            state;
    logic [REF_W-1:0]  ref_cnt;
    logic              ref_pending;
    logic              wr_buf;
    logic              last_complete;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_full;     // frame filled, writes wait for a frame start
    logic              wr_fs_pend;  // frame starts deferred behind an in-flight burst
    logic              rd_fs_pend;

    logic              wr_inflight, rd_inflight, wr_done, rd_done, ref_accept;
    logic              wr_fs_req, rd_fs_req, wr_fs_apply, rd_fs_apply, wr_swap;
    logic              last_complete_nxt, wr_buf_nxt, rd_sel_nxt, wr_full_eff;
    logic              timer_run, wr_ok, rd_ok;
    logic [ADDR_W-1:0] wr_ptr_adv, rd_ptr_adv, wr_ptr_eff, rd_ptr_eff, wr_addr, rd_addr;

    always_comb begin
        wr_inflight = (state == StIssue || state == StBusy) && cmd_op == OpWrite;
        rd_inflight = (state == StIssue || state == StBusy) && cmd_op == OpRead;
        wr_done     = state == StBusy && cmd_done && cmd_op == OpWrite;
        rd_done     = state == StBusy && cmd_done && cmd_op == OpRead;
        ref_accept  = state == StIssue && cmd_ready && cmd_op == OpRefresh;

        wr_ptr_adv = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_STEP;
        rd_ptr_adv = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_STEP;

        wr_fs_req   = wr_frame_start || wr_fs_pend;
        rd_fs_req   = rd_frame_start || rd_fs_pend;
        wr_fs_apply = wr_fs_req && (!wr_inflight || wr_done);
        rd_fs_apply = rd_fs_req && (!rd_inflight || rd_done);
        // A completing write always leaves data behind, so its deferred start swaps.
        wr_swap     = wr_fs_apply && (wr_done || wr_ptr != '0 || wr_full);

        // Write swap resolves first so a same-cycle display start sees the new frame.
        last_complete_nxt = wr_swap ? wr_buf : last_complete;
        wr_buf_nxt        = wr_swap ? ~wr_buf : wr_buf;
        rd_sel_nxt        = (rd_fs_apply && last_complete_nxt != wr_buf_nxt)
                            ? last_complete_nxt : rd_buf_sel;

        // Post-frame-start view used by arbitration so an issued address is never stale.
        wr_ptr_eff  = wr_swap ? '0 : wr_ptr;
        wr_full_eff = wr_swap ? 1'b0 : wr_full;
        rd_ptr_eff  = rd_fs_apply ? '0 : rd_ptr;

        wr_addr = (wr_buf_nxt ? BUF1_BASE : '0) + wr_ptr_eff;
        rd_addr = (rd_sel_nxt ? BUF1_BASE : '0) + rd_ptr_eff;

        timer_run = (state != StWaitInit) || init_done;
        wr_ok     = (wr_fifo_level >= WR_MIN) && !wr_full_eff;
        rd_ok     = rd_fifo_level <= RD_MAX;
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state         <= StWaitInit;
            cmd_valid     <= 1'b0;
            cmd_op        <= 2'b00;
            cmd_addr      <= '0;
            rd_buf_sel    <= 1'b1;
            ref_overrun   <= 1'b0;
            ref_cnt       <= REF_RELOAD;
            ref_pending   <= 1'b0;
            wr_buf        <= 1'b0;
            last_complete <= 1'b1;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            wr_full       <= 1'b0;
            wr_fs_pend    <= 1'b0;
            rd_fs_pend    <= 1'b0;
        end else begin
            // Refresh timer; a new due request overrides the clear of an accepted one.
            if (ref_accept) ref_pending <= 1'b0;
            if (timer_run) begin
                if (ref_cnt == '0) begin
                    ref_cnt     <= REF_RELOAD;
                    ref_pending <= 1'b1;
                    if (ref_pending && !ref_accept) ref_overrun <= 1'b1;
                end else begin
                    ref_cnt <= ref_cnt - 1'b1;
                end
            end

            // Frame bookkeeping; frame starts override the pointer advance.
            wr_fs_pend <= wr_fs_req && !wr_fs_apply;
            rd_fs_pend <= rd_fs_req && !rd_fs_apply;
            if (wr_done) begin
                wr_ptr <= wr_ptr_adv;
                if (wr_ptr == PTR_LAST) wr_full <= 1'b1;
            end
            if (wr_swap) begin
                wr_buf        <= ~wr_buf;
                last_complete <= wr_buf;
                wr_ptr        <= '0;
                wr_full       <= 1'b0;
            end
            if (rd_done) rd_ptr <= rd_ptr_adv;
            if (rd_fs_apply) rd_ptr <= '0;
            rd_buf_sel <= rd_sel_nxt;

            case (state)
                StWaitInit: begin
                    if (init_done) state <= StIdle;
                end
                StIdle: begin
                    if (ref_pending) begin
                        cmd_valid <= 1'b1;
                        cmd_op    <= OpRefresh;
                        cmd_addr  <= '0;
                        state     <= StIssue;
                    end else if (wr_ok) begin
                        cmd_valid <= 1'b1;
                        cmd_op    <= OpWrite;
                        cmd_addr  <= wr_addr;
                        state     <= StIssue;
                    end else if (rd_ok) begin
                        cmd_valid <= 1'b1;
                        cmd_op    <= OpRead;
                        cmd_addr  <= rd_addr;
                        state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= StBusy;
                    end
                end
                StBusy: begin
                    if (cmd_done) state <= StIdle;
                end
                default: state <= StWaitInit;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// tb_sdram_frame_arbiter
//   Directed bench for sdram_frame_arbiter. A small engine model accepts
//   commands, logs them with their acceptance cycle and pulses cmd_done a
//   fixed number of cycles later. The frame is shortened to 8 bursts so a
//   whole-frame write fits in a few dozen cycles.
module tb_sdram_frame_arbiter;

    localparam int unsigned ADDR_W      = 22;
    localparam int unsigned FIFO_AW     = 9;
    localparam int unsigned FRAME_WORDS = 64;
    localparam logic [1:0]  OP_WR       = 2'b01;
    localparam logic [1:0]  OP_RD       = 2'b10;
    localparam logic [1:0]  OP_REF      = 2'b11;
    localparam logic [ADDR_W-1:0] B1    = 22'h200000;

    logic              sys_clk;
    logic              rst;
    logic              init_done;
    logic [FIFO_AW:0]  wr_fifo_level;
    logic [FIFO_AW:0]  rd_fifo_level;
    logic              wr_frame_start;
    logic              rd_frame_start;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_done;
    logic              rd_buf_sel;
    logic              ref_overrun;

    int unsigned tests_run;
    int unsigned tests_failed;
    int unsigned cyc;
    int unsigned done_lat;
    int unsigned done_cnt;
    int unsigned init_cyc;
    logic [1:0]        log_op[$];
    logic [ADDR_W-1:0] log_addr[$];
    int unsigned       log_cyc[$];

    sdram_frame_arbiter #(
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (8),
        .FIFO_AW     (FIFO_AW),
        .FRAME_WORDS (FRAME_WORDS),
        .BUF1_BASE   (B1),
        .REF_INTERVAL(156)
    ) dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .init_done     (init_done),
        .wr_fifo_level (wr_fifo_level),
        .rd_fifo_level (rd_fifo_level),
        .wr_frame_start(wr_frame_start),
        .rd_frame_start(rd_frame_start),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_done      (cmd_done),
        .rd_buf_sel    (rd_buf_sel),
        .ref_overrun   (ref_overrun)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge sys_clk);
            cyc = cyc + 1;
        end
    end

    // Engine model: a handshake seen at a negedge is accepted on the next posedge.
    initial begin
        done_cnt = 0;
        cmd_done = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (rst) begin
                done_cnt = 0;
                cmd_done = 1'b0;
            end else begin
                cmd_done = 1'b0;
                if (done_cnt != 0) begin
                    done_cnt = done_cnt - 1;
                    if (done_cnt == 0) cmd_done = 1'b1;
                end
                if (cmd_valid && cmd_ready) begin
                    done_cnt = done_lat;
                    log_op.push_back(cmd_op);
                    log_addr.push_back(cmd_addr);
                    log_cyc.push_back(cyc + 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        init_done      = 1'b0;
        wr_fifo_level  = '0;
        rd_fifo_level  = 10'd512;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        cmd_ready      = 1'b1;
        done_lat       = 4;
        step(3);
        log_op.delete();
        log_addr.delete();
        log_cyc.delete();
        rst = 1'b0;
        step(1);
    endtask

    task automatic start_init();
        init_done = 1'b1;
        init_cyc  = cyc + 1;
    endtask

    task automatic wait_cmds(input int n, input int limit, input string name);
        for (int i = 0; i < limit && log_op.size() < n; i++) step(1);
        tests_run++;
        if (log_op.size() < n) begin
            tests_failed++;
            $display("FAIL %s_timeout: got %0d commands, required %0d", name, log_op.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        init_done = 1'b0;
        wr_fifo_level = 10'd8;
        rd_fifo_level = 10'd0;
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b0;
        cmd_ready = 1'b1;
        done_lat = 4;
        step(2);
        tests_run++;
        if (cmd_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_cmd_valid: got %b, required 0", cmd_valid);
        end
        tests_run++;
        if (cmd_op !== 2'b00) begin
            tests_failed++; $display("FAIL reset_cmd_op: got %b, required 00", cmd_op);
        end
        tests_run++;
        if (cmd_addr !== '0) begin
            tests_failed++; $display("FAIL reset_cmd_addr: got %h, required 0", cmd_addr);
        end
        tests_run++;
        if (rd_buf_sel !== 1'b1) begin
            tests_failed++; $display("FAIL reset_rd_buf_sel: got %b, required 1", rd_buf_sel);
        end
        tests_run++;
        if (ref_overrun !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ref_overrun: got %b, required 0", ref_overrun);
        end
        log_op.delete();
        log_addr.delete();
        log_cyc.delete();
        rst = 1'b0;
        // Work is eligible but init_done is low: nothing may be issued.
        step(20);
        tests_run++;
        if (cmd_valid !== 1'b0 || log_op.size() != 0) begin
            tests_failed++;
            $display("FAIL no_cmd_before_init: got valid=%b count=%0d, required 0/0",
                     cmd_valid, log_op.size());
        end
    endtask

    task automatic test_refresh_only();
        do_reset();
        step(10);
        start_init();
        wait_cmds(3, 700, "refresh");
        if (log_op.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (log_op[i] !== OP_REF || log_addr[i] !== '0) begin
                    tests_failed++;
                    $display("FAIL refresh_cmd%0d: got op=%b addr=%h, required 11/0",
                             i, log_op[i], log_addr[i]);
                end
            end
            tests_run++;
            if (log_cyc[0] - init_cyc != 157) begin
                tests_failed++;
                $display("FAIL refresh_first: got %0d cycles after init, required 157",
                         log_cyc[0] - init_cyc);
            end
            for (int i = 1; i < 3; i++) begin
                tests_run++;
                if (log_cyc[i] - log_cyc[i-1] != 156) begin
                    tests_failed++;
                    $display("FAIL refresh_interval%0d: got %0d, required 156",
                             i, log_cyc[i] - log_cyc[i-1]);
                end
            end
        end
        tests_run++;
        if (ref_overrun !== 1'b0) begin
            tests_failed++; $display("FAIL refresh_overrun: got %b, required 0", ref_overrun);
        end
    endtask

    task automatic test_write_bursts();
        int unsigned n_wr;
        do_reset();
        wr_fifo_level = 10'd8;
        start_init();
        wait_cmds(8, 200, "write");
        if (log_op.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                tests_run++;
                if (log_op[i] !== OP_WR || log_addr[i] !== ADDR_W'(i * 8)) begin
                    tests_failed++;
                    $display("FAIL write_burst%0d: got op=%b addr=%h, required 01/%h",
                             i, log_op[i], log_addr[i], i * 8);
                end
            end
        end
        // Frame full: writes must stall until the next frame start.
        step(200);
        n_wr = 0;
        foreach (log_op[i]) if (log_op[i] == OP_WR) n_wr++;
        tests_run++;
        if (n_wr != 8) begin
            tests_failed++;
            $display("FAIL write_hold_after_wrap: got %0d writes, required 8", n_wr);
        end
    endtask

    task automatic test_write_read_priority();
        logic [1:0]        exp_op[4];
        logic [ADDR_W-1:0] exp_addr[4];
        exp_op   = '{OP_WR, OP_WR, OP_RD, OP_RD};
        exp_addr = '{22'h0, 22'h8, B1, B1 + 22'h8};
        do_reset();
        wr_fifo_level = 10'd8;
        rd_fifo_level = 10'd0;
        start_init();
        wait_cmds(2, 50, "wr_rd_write");
        wr_fifo_level = 10'd0;
        wait_cmds(4, 50, "wr_rd_read");
        if (log_op.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (log_op[i] !== exp_op[i] || log_addr[i] !== exp_addr[i]) begin
                    tests_failed++;
                    $display("FAIL wr_rd_cmd%0d: got op=%b addr=%h, required %b/%h",
                             i, log_op[i], log_addr[i], exp_op[i], exp_addr[i]);
                end
            end
        end
    endtask

    task automatic test_frame_swap();
        do_reset();
        wr_fifo_level = 10'd8;
        start_init();
        wait_cmds(8, 200, "swap_fill");
        step(10);
        wr_frame_start = 1'b1;
        step(1);
        wr_frame_start = 1'b0;
        rd_frame_start = 1'b1;
        step(1);
        rd_frame_start = 1'b0;
        wait_cmds(9, 50, "swap_write");
        wr_fifo_level = 10'd0;
        rd_fifo_level = 10'd0;
        tests_run++;
        if (rd_buf_sel !== 1'b0) begin
            tests_failed++; $display("FAIL swap_rd_buf_sel: got %b, required 0", rd_buf_sel);
        end
        wait_cmds(10, 50, "swap_read");
        if (log_op.size() >= 10) begin
            tests_run++;
            if (log_op[8] !== OP_WR || log_addr[8] !== B1) begin
                tests_failed++;
                $display("FAIL swap_write_base: got op=%b addr=%h, required 01/%h",
                         log_op[8], log_addr[8], B1);
            end
            tests_run++;
            if (log_op[9] !== OP_RD || log_addr[9] !== '0) begin
                tests_failed++;
                $display("FAIL swap_read_base: got op=%b addr=%h, required 10/0",
                         log_op[9], log_addr[9]);
            end
        end
    endtask

    task automatic test_deferred_swap();
        do_reset();
        wr_fifo_level = 10'd8;
        start_init();
        wait_cmds(1, 20, "defer_first");
        // First write is now in BUSY.
        wr_frame_start = 1'b1;
        step(1);
        wr_frame_start = 1'b0;
        wait_cmds(2, 30, "defer_next");
        if (log_op.size() >= 2) begin
            tests_run++;
            if (log_op[0] !== OP_WR || log_addr[0] !== '0) begin
                tests_failed++;
                $display("FAIL defer_cur_burst: got op=%b addr=%h, required 01/0",
                         log_op[0], log_addr[0]);
            end
            tests_run++;
            if (log_op[1] !== OP_WR || log_addr[1] !== B1) begin
                tests_failed++;
                $display("FAIL defer_next_burst: got op=%b addr=%h, required 01/%h",
                         log_op[1], log_addr[1], B1);
            end
        end
        tests_run++;
        if (rd_buf_sel !== 1'b1) begin
            tests_failed++; $display("FAIL defer_sel_before: got %b, required 1", rd_buf_sel);
        end
        rd_frame_start = 1'b1;
        step(1);
        rd_frame_start = 1'b0;
        step(1);
        tests_run++;
        if (rd_buf_sel !== 1'b0) begin
            tests_failed++; $display("FAIL defer_sel_after: got %b, required 0", rd_buf_sel);
        end
    endtask

    task automatic test_stall_overrun();
        do_reset();
        wr_fifo_level = 10'd8;
        cmd_ready = 1'b0;
        start_init();
        step(5);
        tests_run++;
        if (cmd_valid !== 1'b1 || cmd_op !== OP_WR || cmd_addr !== '0) begin
            tests_failed++;
            $display("FAIL stall_t5: got v=%b op=%b addr=%h, required 1/01/0",
                     cmd_valid, cmd_op, cmd_addr);
        end
        step(195);
        tests_run++;
        if (cmd_valid !== 1'b1 || cmd_op !== OP_WR || cmd_addr !== '0 || ref_overrun !== 1'b0)
        begin
            tests_failed++;
            $display("FAIL stall_t200: got v=%b op=%b addr=%h ovr=%b, required 1/01/0/0",
                     cmd_valid, cmd_op, cmd_addr, ref_overrun);
        end
        step(200);
        tests_run++;
        if (cmd_valid !== 1'b1 || cmd_op !== OP_WR || cmd_addr !== '0 || ref_overrun !== 1'b1)
        begin
            tests_failed++;
            $display("FAIL stall_t400: got v=%b op=%b addr=%h ovr=%b, required 1/01/0/1",
                     cmd_valid, cmd_op, cmd_addr, ref_overrun);
        end
        // Release: the pending refresh must beat the still-eligible write.
        cmd_ready = 1'b1;
        wait_cmds(3, 60, "stall_release");
        if (log_op.size() >= 3) begin
            tests_run++;
            if (log_op[0] !== OP_WR || log_op[1] !== OP_REF || log_op[2] !== OP_WR) begin
                tests_failed++;
                $display("FAIL refresh_priority: got ops %b,%b,%b, required 01,11,01",
                         log_op[0], log_op[1], log_op[2]);
            end
            tests_run++;
            if (log_addr[2] !== 22'h8) begin
                tests_failed++;
                $display("FAIL stall_next_addr: got %h, required 8", log_addr[2]);
            end
        end
        tests_run++;
        if (ref_overrun !== 1'b1) begin
            tests_failed++; $display("FAIL overrun_sticky: got %b, required 1", ref_overrun);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        wr_fifo_level = 10'd8;
        cmd_ready = 1'b0;
        start_init();
        step(320);
        tests_run++;
        if (cmd_valid !== 1'b1 || ref_overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_pre: got v=%b ovr=%b, required 1/1", cmd_valid, ref_overrun);
        end
        // Assert reset between clock edges; outputs must clear without a clock.
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (cmd_valid !== 1'b0 || cmd_op !== 2'b00 || cmd_addr !== '0 ||
            rd_buf_sel !== 1'b1 || ref_overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got v=%b op=%b addr=%h sel=%b ovr=%b, required 0/00/0/1/0",
                     cmd_valid, cmd_op, cmd_addr, rd_buf_sel, ref_overrun);
        end
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_refresh_only();
        test_write_bursts();
        test_write_read_priority();
        test_frame_swap();
        test_deferred_swap();
        test_stall_overrun();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sdram_frame_arbiter.md
Name: sdram_frame_arbiter

Overview:
- Schedules the single SDRAM burst controller between three requesters: camera write FIFO (OV7670 capture path), VGA read FIFO (display path) and periodic auto-refresh.
- Generates burst addresses for a two-buffer ping-pong frame store, so the display always reads the last complete camera frame.
- Sits between the capture/display FIFOs and the SDRAM command engine, in the sys_clk domain.

Parameters:
- ADDR_W, 22, SDRAM word address width (bank 2 + row 12 + col 8).
- BURST_LEN, 8, words per read/write burst; power of two.
- FIFO_AW, 9, FIFO address width; level ports are FIFO_AW+1 bits.
- FRAME_WORDS, 307200, 16-bit words per frame (640x480); multiple of BURST_LEN.
- BUF1_BASE, 22'h200000, word base of buffer 1; buffer 0 base is 0.
- REF_INTERVAL, 156, sys_clk cycles between refresh requests (7.8 us at 20 MHz).

Ports:
- sys_clk, in, 1, system clock; all logic on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- init_done, in, 1, SDRAM power-up initialisation complete; no commands before it is high.
- wr_fifo_level, in, FIFO_AW+1, words held in the camera write FIFO.
- rd_fifo_level, in, FIFO_AW+1, words held in the VGA read FIFO.
- wr_frame_start, in, 1, one-cycle pulse at camera frame start (synchronised vsync).
- rd_frame_start, in, 1, one-cycle pulse at VGA frame start.
- cmd_valid, out, 1, command request to the SDRAM engine.
- cmd_ready, in, 1, engine accepts the command when cmd_valid && cmd_ready.
- cmd_op, out, 2, 01 write burst, 10 read burst, 11 auto-refresh; 00 never issued.
- cmd_addr, out, ADDR_W, burst start word address; 0 for refresh.
- cmd_done, in, 1, one-cycle pulse when the accepted command has completed.
- rd_buf_sel, out, 1, buffer currently displayed.
- ref_overrun, out, 1, sticky flag: a refresh came due while one was already pending.

Behaviour:
- Reset values: cmd_valid 0, cmd_op 00, cmd_addr 0, rd_buf_sel 1, ref_overrun 0. Write buffer = 0, both pointers = 0, refresh timer = REF_INTERVAL-1, ref_pending 0. Reset mid-burst abandons it at once; the engine is reset by the same rst.
- Refresh timer: counts down only while init_done=1. On reaching 0 it reloads REF_INTERVAL-1 and sets ref_pending. If ref_pending is already 1, ref_overrun is set and stays set until rst.
- FSM states: WAIT_INIT, IDLE, ISSUE, BUSY.
- WAIT_INIT -> IDLE when init_done=1.
- IDLE arbitration, evaluated every cycle, fixed priority:
  1. ref_pending -> refresh.
  2. wr_fifo_level >= BURST_LEN -> write.
  3. (2^FIFO_AW - rd_fifo_level) >= BURST_LEN -> read.
  Otherwise stay in IDLE.
  The chosen op and address are registered, so cmd_valid rises the cycle after the decision and the FSM enters ISSUE.
- ISSUE: cmd_valid, cmd_op and cmd_addr are held stable until cmd_ready. On the handshake, cmd_valid drops the same edge -> BUSY. An accepted refresh clears ref_pending.
- BUSY: wait for cmd_done -> IDLE. Pointer advance happens on cmd_done, not at acceptance. Minimum spacing between commands: 2 cycles after cmd_done.
- Write address = write buffer base + wr_ptr. Read address = base of rd_buf_sel + rd_ptr. Pointers advance by BURST_LEN.
- At FRAME_WORDS-BURST_LEN + BURST_LEN a pointer wraps to 0, i.e. it never reaches FRAME_WORDS. No writes occur while the write pointer is wrapped and waiting for a frame start.
- wr_frame_start:
  - If wr_ptr != 0, the current frame is complete or partial: mark the write buffer as last_complete, toggle the write buffer, clear wr_ptr.
  - If wr_ptr == 0 (no data yet), ignore it.
  - If it arrives in ISSUE/BUSY on a write, latch it and apply it after that write's cmd_done.
- rd_frame_start: rd_buf_sel <= last_complete and rd_ptr <= 0. Same latch-and-defer rule if a read is in flight.
- Same-cycle wr_frame_start and rd_frame_start: the write swap is applied first, so the display takes the buffer just completed.
- The read side never selects the buffer currently being written. If last_complete equals the write buffer, rd_buf_sel keeps its old value.
- init_done falling mid-operation is ignored; init_done is only sampled in WAIT_INIT.

Test Plan:
- Reset then init_done=1 at cycle 10, FIFOs empty and rd_fifo_level=512 -> only refreshes issued: cmd_op=11 every 156 cycles, cmd_addr=0, ref_overrun stays 0.
- wr_fifo_level=8, rd_fifo_level=512, cmd_ready=1, cmd_done 4 cycles after acceptance -> write bursts at addresses 0, 8, 16 …; a refresh coming due in the same cycle wins arbitration.
- Write and read both eligible (wr_fifo_level=8, rd_fifo_level=0) -> write granted first; read at buffer-1 base 0x200000 only when wr_fifo_level<8.
- Write 307200 words, then wr_frame_start, then rd_frame_start -> write base switches to 0x200000, rd_buf_sel=0, reads start at address 0.
- wr_frame_start pulsed during a write's BUSY state -> current burst completes at its address, swap applied on cmd_done, next write at the new base offset 0.
- cmd_ready held 0 for 400 cycles -> cmd_valid, cmd_op and cmd_addr remain stable; ref_overrun=1 once a second refresh comes due; rst=1 clears all outputs asynchronously.
